// File: rtl/otter_bus_demux.sv
// 1-to-2 request router for the OTTER memory bus: registers each request, forwards it to
// data memory (T0) or MMIO (T1) by address, and steers responses back in issue order.
module otter_bus_demux #(
    parameter logic [31:0] MMIO_BASE = 32'h1100_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_ADDR,
    input  logic        IN_WE,
    input  logic [31:0] IN_WDATA,
    input  logic [3:0]  IN_BE,
    output logic        IN_RVALID,
    output logic [31:0] IN_RDATA,
    output logic        T0_VALID,
    input  logic        T0_READY,
    output logic        T1_VALID,
    input  logic        T1_READY,
    output logic [31:0] T_ADDR,
    output logic        T_WE,
    output logic [31:0] T_WDATA,
    output logic [3:0]  T_BE,
    input  logic        T0_RVALID,
    input  logic [31:0] T0_RDATA,
    input  logic        T1_RVALID,
    input  logic [31:0] T1_RDATA,
    output logic        ORDER_ERR
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic             req_v;
    logic             req_tgt;
    logic             sel_ready;
    logic             accept;
    logic             issue;

    logic [DEPTH-1:0] fifo_tgt;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             nonempty;
    logic             head;
    logic             bad_rsp;

    // Request register and routing
    assign sel_ready = req_tgt ? T1_READY : T0_READY;
    assign issue     = req_v & sel_ready;
    assign IN_READY  = (~req_v | sel_ready) & (count < FULL);
    assign accept    = IN_VALID & IN_READY;
    assign T0_VALID  = req_v & ~req_tgt;
    assign T1_VALID  = req_v & req_tgt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_v   <= 1'b0;
            req_tgt <= 1'b0;
            T_ADDR  <= '0;
            T_WE    <= 1'b0;
            T_WDATA <= '0;
            T_BE    <= '0;
        end else if (accept) begin
            req_v   <= 1'b1;
            req_tgt <= (IN_ADDR >= MMIO_BASE);
            T_ADDR  <= IN_ADDR;
            T_WE    <= IN_WE;
            T_WDATA <= IN_WDATA;
            T_BE    <= IN_BE;
        end else if (issue) begin
            req_v   <= 1'b0;
        end
    end

    // Order tracking: one target bit per accepted, unanswered request
    assign nonempty  = (count != '0);
    assign head      = fifo_tgt[rd_ptr];
    assign IN_RVALID = nonempty & (head ? T1_RVALID : T0_RVALID);
    assign IN_RDATA  = IN_RVALID ? (head ? T1_RDATA : T0_RDATA) : '0;

    // Any response that is not the head target's is a protocol violation and is dropped
    assign bad_rsp = (T0_RVALID & ~(nonempty & ~head)) |
                     (T1_RVALID & ~(nonempty &  head));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_tgt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ORDER_ERR <= 1'b0;
        end else begin
            if (accept) begin
                fifo_tgt[wr_ptr] <= (IN_ADDR >= MMIO_BASE);
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (IN_RVALID)
                rd_ptr <= rd_ptr + PW'(1);
            if (accept && !IN_RVALID)
                count <= count + (PW+1)'(1);
            else if (!accept && IN_RVALID)
                count <= count - (PW+1)'(1);
            if (bad_rsp)
                ORDER_ERR <= 1'b1;
        end
    end
endmodule
